// File: rtl/cpu_clk_ctrl_pkg.sv
// rtl/cpu_clk_ctrl_pkg.sv - shared types and helpers for the CPU run/step/halt controller
// Contents: ctrl_state_t (HALT/RUN/STEP encoding seen on the state port) and
// tick_mask(), the prescaler tap mask with div_sel clamping.
package cpu_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } ctrl_state_t;

    // Mask of (sel+1) low ones; sel values past the counter top clamp to the MSB tap.
    function automatic logic [31:0] tick_mask(input logic [4:0] sel, input int cnt_w);
        int n;
        n = (int'(sel) >= cnt_w) ? cnt_w - 1 : int'(sel);
        return 32'((64'd1 << (n + 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// rtl/cpu_clk_ctrl_btn_debounce.sv - two-flop synchroniser plus consecutive-cycle debouncer
// Ports: clk, rst (async, active high), raw_i (asynchronous button), db_o (debounced level).
// db_o takes the synchronised level once it has differed from db_o for DEB_CYC
// consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce #(
    parameter int DEB_CYC = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o
);

    localparam int DW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

    logic          meta_q;
    logic          sync_q;
    logic          db_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            if (sync_q != db_q) begin
                // This cycle is the DEB_CYC-th consecutive disagreement.
                if (cnt_q == DW'(DEB_CYC - 1)) begin
                    db_q  <= sync_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - single-clock run/step/halt controller issuing cpu_ce to the 4-bit CPU and RAM
// Ports: clk, rst (async, active high), run, step_btn, btn_raw (raw asynchronous inputs),
// div_sel (prescaler tap), cpu_ce (one-cycle enable), btn_db (debounced buttons),
// state (0 HALT / 1 RUN / 2 STEP), cyc_cnt (issued enables, wrapping).
// Optional: CPU_CLK_CTRL_BREAKPOINT_EN adds cpu_adr, bp_en, bp_addr, bp_hit.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int NUM_BTN = 4,
    parameter int DEB_CYC = 65535,
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    parameter int ADR_W   = 4,
`endif
    parameter int CYC_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step_btn,
    input  logic [4:0]         div_sel,
    input  logic [NUM_BTN-1:0] btn_raw,
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    input  logic [ADR_W-1:0]   cpu_adr,
    input  logic               bp_en,
    input  logic [ADR_W-1:0]   bp_addr,
    output logic               bp_hit,
`endif
    output logic               cpu_ce,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [1:0]         state,
    output logic [CYC_W-1:0]   cyc_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic             run_meta_q;
    logic             run_s_q;
    logic             step_db;
    logic             step_prev_q;
    logic             bp_hit_q;
    logic [CYC_W-1:0] cyc_q;
    ctrl_state_t      state_q;

    logic [31:0]      mask;
    logic             tick;
    logic             step_pulse;
    logic             bp_match;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEB_CYC(DEB_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw_i (btn_raw[i]),
            .db_o  (btn_db[i])
        );
    end

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .raw_i (step_btn),
        .db_o  (step_db)
    );

    assign mask       = tick_mask(div_sel, CNT_W);
    assign tick       = ((32'(cnt_q) & mask) == mask);
    assign step_pulse = step_db & ~step_prev_q;

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    assign bp_match = bp_en && (cpu_adr == bp_addr);
    assign bp_hit   = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    // A breakpoint match swallows the RUN tick; STEP never looks at the address.
    assign cpu_ce = tick && (((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP));

    // Run is only synchronised: a bouncing switch at worst toggles RUN/HALT briefly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            cyc_q      <= '0;
        end else begin
            cnt_q      <= cnt_q + 1'b1;
            run_meta_q <= run;
            run_s_q    <= run_meta_q;
            if (cpu_ce) begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALT;
            bp_hit_q    <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step_db;
            if (!run_s_q) begin
                bp_hit_q <= 1'b0;
            end
            case (state_q)
                ST_HALT: begin
                    if (run_s_q && !bp_hit_q) begin
                        state_q <= ST_RUN;
                    end else if (step_pulse) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (tick && bp_match) begin
                        state_q  <= ST_HALT;
                        bp_hit_q <= 1'b1;
                    end else if (!run_s_q) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    if (tick) begin
                        state_q  <= ST_HALT;
                        bp_hit_q <= 1'b0;
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign state   = state_q;
    assign cyc_cnt = cyc_q;

endmodule
